// File: rtl/fifo4_16.sv
// Four-entry, 16-bit synchronous FIFO with valid/ready handshakes on both sides.
// The head word is selected from four storage registers by a 4-way 16-bit mux
// driven by the read pointer. Full/empty come from the occupancy count, which
// also serves as the EMPTY (0) / PARTIAL (1..3) / FULL (4) state.
// Handshake: a side transfers on a rising edge only when its valid and ready
// are both high at that edge. out_valid/in_ready depend on registered state only.

module mux4way16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [15:0] c_i,
   input  logic [15:0] d_i,
   input  logic [1:0]  sel_i,
   output logic [15:0] out_o
);

   // Pick one of four words by the 2-bit select
   always_comb begin
      out_o = a_i;
      case (sel_i)
         2'd0: out_o = a_i;
         2'd1: out_o = b_i;
         2'd2: out_o = c_i;
         2'd3: out_o = d_i;
         default: out_o = a_i;
      endcase
   end

endmodule

module fifo4_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [2:0]       count,
   output logic [1:0]       rd_ptr
);

   logic [WIDTH-1:0] mem_q [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;
   logic             push, pop;

   // Handshake qualifiers and flag outputs, all from registered count
   always_comb begin
      in_ready  = (count_q != 3'd4);
      out_valid = (count_q != 3'd0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Next pointer/count values; flush discards any concurrent push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
         count_d  = 3'd0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
         if (push && !pop)      count_d = count_q + 3'd1;
         else if (pop && !push) count_d = count_q - 3'd1;
      end
   end

   // Pointer and count registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage: write the slot at wr_ptr on an accepted push; popped words stay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else if (push && !flush) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   mux4way16 u_head_mux (
      .a_i   (mem_q[0]),
      .b_i   (mem_q[1]),
      .c_i   (mem_q[2]),
      .d_i   (mem_q[3]),
      .sel_i (rd_ptr_q),
      .out_o (out_data)
   );

   assign count  = count_q;
   assign rd_ptr = rd_ptr_q;

endmodule

// File: tb/tb_fifo4_16.sv
// Directed bench for fifo4_16: a vector table for the per-cycle protocol plus
// hand-written sequences for reset behaviour, flush and mid-cycle async reset.

module tb_fifo4_16;

   logic        clk;
   logic        rst;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [2:0]  count;
   logic [1:0]  rd_ptr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic        fl;
      logic [2:0]  e_count;
      logic [15:0] e_data;
      logic [1:0]  e_rd;
   } vec_t;

   vec_t vecs[$];

   fifo4_16 dut (
      .clk       (clk),
      .rst       (rst),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .count     (count),
      .rd_ptr    (rd_ptr)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Full output check given the expected count; flags follow from count
   task automatic chk_all(input string tag, input logic [2:0] e_count,
                          input logic [15:0] e_data, input logic [1:0] e_rd);
      chk({tag, ".count"},     {13'd0, count},     {13'd0, e_count});
      chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, (e_count != 3'd0)});
      chk({tag, ".in_ready"},  {15'd0, in_ready},  {15'd0, (e_count != 3'd4)});
      chk({tag, ".rd_ptr"},    {14'd0, rd_ptr},    {14'd0, e_rd});
      chk({tag, ".out_data"},  out_data,           e_data);
   endtask

   task automatic add(input logic iv, input logic [15:0] id, input logic ordy, input logic fl,
                      input logic [2:0] e_count, input logic [15:0] e_data, input logic [1:0] e_rd);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.e_count = e_count; v.e_data = e_data; v.e_rd = e_rd;
      vecs.push_back(v);
   endtask

   // Drive inputs at the falling edge, clock once, sample 1 ns after the edge
   task automatic step(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0; flush = 1'b0;

      // Reset held with a push presented: nothing may be stored
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 3'd0, 16'h0000, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_all("post_reset", 3'd0, 16'h0000, 2'd0);

      // iv, data, out_ready, flush -> count, out_data, rd_ptr after the edge
      // fill, refused 5th push, drain in order
      add(1, 16'h000f, 0, 0, 3'd1, 16'h000f, 2'd0);
      add(1, 16'h00f0, 0, 0, 3'd2, 16'h000f, 2'd0);
      add(1, 16'h0f00, 0, 0, 3'd3, 16'h000f, 2'd0);
      add(1, 16'hf000, 0, 0, 3'd4, 16'h000f, 2'd0);
      add(1, 16'hdead, 0, 0, 3'd4, 16'h000f, 2'd0);
      add(0, 16'h0000, 1, 0, 3'd3, 16'h00f0, 2'd1);
      add(0, 16'h0000, 1, 0, 3'd2, 16'h0f00, 2'd2);
      add(0, 16'h0000, 1, 0, 3'd1, 16'hf000, 2'd3);
      add(0, 16'h0000, 1, 0, 3'd0, 16'h000f, 2'd0);
      // wrap: 3 in, 3 out, then aaaa->slot3, bbbb->slot0, cccc->slot1
      add(1, 16'h1111, 0, 0, 3'd1, 16'h1111, 2'd0);
      add(1, 16'h2222, 0, 0, 3'd2, 16'h1111, 2'd0);
      add(1, 16'h3333, 0, 0, 3'd3, 16'h1111, 2'd0);
      add(0, 16'h0000, 1, 0, 3'd2, 16'h2222, 2'd1);
      add(0, 16'h0000, 1, 0, 3'd1, 16'h3333, 2'd2);
      add(0, 16'h0000, 1, 0, 3'd0, 16'hf000, 2'd3);
      add(1, 16'haaaa, 0, 0, 3'd1, 16'haaaa, 2'd3);
      add(1, 16'hbbbb, 0, 0, 3'd2, 16'haaaa, 2'd3);
      add(1, 16'hcccc, 0, 0, 3'd3, 16'haaaa, 2'd3);
      add(0, 16'h0000, 1, 0, 3'd2, 16'hbbbb, 2'd0);
      // simultaneous push/pop at count 2
      add(1, 16'hdddd, 1, 0, 3'd2, 16'hcccc, 2'd1);
      // fill to 4, then push+pop while full: pop only, next push accepted
      add(1, 16'heeee, 0, 0, 3'd3, 16'hcccc, 2'd1);
      add(1, 16'h1357, 0, 0, 3'd4, 16'hcccc, 2'd1);
      add(1, 16'h9999, 1, 0, 3'd3, 16'hdddd, 2'd2);
      add(1, 16'h9999, 0, 0, 3'd4, 16'hdddd, 2'd2);
      add(0, 16'h0000, 1, 0, 3'd3, 16'heeee, 2'd3);
      add(0, 16'h0000, 1, 0, 3'd2, 16'h1357, 2'd0);
      add(0, 16'h0000, 1, 0, 3'd1, 16'h9999, 2'd1);
      add(0, 16'h0000, 1, 0, 3'd0, 16'hdddd, 2'd2);
      // push into empty with out_ready high: stored, popped one edge later
      add(1, 16'h5a5a, 1, 0, 3'd1, 16'h5a5a, 2'd2);
      add(0, 16'h0000, 1, 0, 3'd0, 16'heeee, 2'd3);
      // flush at count 3 with concurrent push/pop; storage is kept
      add(1, 16'h0101, 0, 0, 3'd1, 16'h0101, 2'd3);
      add(1, 16'h0202, 0, 0, 3'd2, 16'h0101, 2'd3);
      add(1, 16'h0303, 0, 0, 3'd3, 16'h0101, 2'd3);
      add(1, 16'hffff, 1, 1, 3'd0, 16'h0202, 2'd0);
      add(1, 16'h4444, 0, 0, 3'd1, 16'h4444, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 28) begin
            // last vector left the FIFO empty; check before the 5a5a edge
            chk("empty_before_push.out_valid", {15'd0, out_valid}, 16'd0);
         end
         step(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
         chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_data, vecs[i].e_rd);
      end

      // Fill to 4 then pulse rst between edges: clears before the next edge
      step(1, 16'h5555, 0, 0);
      step(1, 16'h6666, 0, 0);
      step(1, 16'h7777, 0, 0);
      chk_all("full_before_rst", 3'd4, 16'h4444, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk_all("async_rst", 3'd0, 16'h0000, 2'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_all("after_async_rst", 3'd0, 16'h0000, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
